// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM state encoding,
// default data width, default halt opcode and default reset PC.
package fetch_pkg;

    localparam int          FETCH_DATA_WIDTH  = 16;
    localparam logic [15:0] FETCH_HALT_OPCODE = 16'hFFFF;
    localparam logic [15:0] FETCH_RESET_PC    = 16'h0000;

    typedef enum logic {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/fetch_pc.sv
// Program counter register for the fetch unit.
// Ports: clk, rst_n (sync, active-low), inc_en_i (advance by one),
//        load_en_i/target_i (redirect, wins over increment), pc_o.
module fetch_pc #(
    parameter int             W        = 16,
    parameter logic [W-1:0]   RESET_PC = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en_i,
    input  logic         load_en_i,
    input  logic [W-1:0] target_i,
    output logic [W-1:0] pc_o
);

    logic [W-1:0] pc_q;
    logic [W-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (load_en_i) begin
            pc_d = target_i;
        end else if (inc_en_i) begin
            // Natural modulo-2^W wrap.
            pc_d = pc_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC-addressed ROM read, one-entry instruction
// register with valid/ready handshake, branch redirect, HALT detection.
// Ports: clk, rst_n (sync, active-low), rom_addr/rom_opcode/rom_operand,
//        branch_valid/branch_target, instr_valid/instr_ready,
//        instr_opcode/instr_operand/instr_pc, halted, fetch_count.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                      DATA_WIDTH  = FETCH_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0]   RESET_PC    = FETCH_RESET_PC,
    parameter logic [DATA_WIDTH-1:0]   HALT_OPCODE = FETCH_HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [DATA_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_opcode,
    input  logic [DATA_WIDTH-1:0] rom_operand,
    input  logic                  branch_valid,
    input  logic [DATA_WIDTH-1:0] branch_target,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_opcode,
    output logic [DATA_WIDTH-1:0] instr_operand,
    output logic [DATA_WIDTH-1:0] instr_pc,
    output logic                  halted,
    output logic [DATA_WIDTH-1:0] fetch_count
);

    state_e                state_q, state_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] opc_q, opc_d;
    logic [DATA_WIDTH-1:0] opd_q, opd_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] pc;

    logic load;
    logic is_halt;
    logic accept;
    logic fetch_en;

    // Instruction register is free when empty or being drained this cycle.
    assign load     = (state_q == ST_FETCH) && !branch_valid
                      && (!valid_q || instr_ready);
    assign is_halt  = (rom_opcode == HALT_OPCODE);
    assign accept   = valid_q && instr_ready;
    assign fetch_en = load && !is_halt;

    fetch_pc #(
        .W        (DATA_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en_i  (fetch_en),
        .load_en_i (branch_valid),
        .target_i  (branch_target),
        .pc_o      (pc)
    );

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        opc_d   = opc_q;
        opd_d   = opd_q;
        ipc_d   = ipc_q;
        if (branch_valid) begin
            state_d = ST_FETCH;
            valid_d = 1'b0;
        end else if (load) begin
            if (is_halt) begin
                // HALT word is consumed here and never presented.
                state_d = ST_HALTED;
                valid_d = 1'b0;
            end else begin
                valid_d = 1'b1;
                opc_d   = rom_opcode;
                opd_d   = rom_operand;
                ipc_d   = pc;
            end
        end
    end

    // A handshake coinciding with a branch still counts.
    assign cnt_d = accept ? cnt_q + DATA_WIDTH'(1) : cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
            valid_q <= 1'b0;
            opc_q   <= '0;
            opd_q   <= '0;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            opc_q   <= opc_d;
            opd_q   <= opd_d;
            ipc_q   <= ipc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rom_addr      = pc;
    assign instr_valid   = valid_q;
    assign instr_opcode  = opc_q;
    assign instr_operand = opd_q;
    assign instr_pc      = ipc_q;
    assign halted        = (state_q == ST_HALTED);
    assign fetch_count   = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table plus hand-written
// HALT and PC-wrap sequences, with an accepted-instruction scoreboard.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] rom_addr;
    logic [15:0] rom_opcode;
    logic [15:0] rom_operand;
    logic        branch_valid = 1'b0;
    logic [15:0] branch_target = 16'h0000;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instr_opcode;
    logic [15:0] instr_operand;
    logic [15:0] instr_pc;
    logic        halted;
    logic [15:0] fetch_count;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [0:15];

    always #5 clk = ~clk;

    assign {rom_opcode, rom_operand} =
        (rom_addr == 16'hFFFF) ? 32'h00AA_0055 :
        (rom_addr < 16'd16)    ? mem[rom_addr[3:0]] : 32'h0000_0000;

    fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rom_addr      (rom_addr),
        .rom_opcode    (rom_opcode),
        .rom_operand   (rom_operand),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_opcode  (instr_opcode),
        .instr_operand (instr_operand),
        .instr_pc      (instr_pc),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    typedef struct {
        logic [15:0] pc;
        logic [15:0] op;
        logic [15:0] opd;
    } sb_t;

    sb_t sbq[$];

    typedef struct {
        bit          rst;
        bit          rdy;
        bit          br;
        logic [15:0] tgt;
        bit          e_valid;
        logic [15:0] e_pc;
        logic [15:0] e_op;
        logic [15:0] e_opd;
        logic [15:0] e_addr;
        bit          e_halt;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl [16];

    function automatic vec_t mk(
        bit rst, bit rdy, bit br, logic [15:0] tgt,
        bit v, logic [15:0] pc, logic [15:0] op, logic [15:0] opd,
        logic [15:0] addr, bit h, logic [15:0] cnt);
        vec_t r;
        r.rst = rst; r.rdy = rdy; r.br = br; r.tgt = tgt;
        r.e_valid = v; r.e_pc = pc; r.e_op = op; r.e_opd = opd;
        r.e_addr = addr; r.e_halt = h; r.e_cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name,
                       input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc,
                        input logic [15:0] op,
                        input logic [15:0] opd);
        sb_t e;
        e.pc = pc; e.op = op; e.opd = opd;
        sbq.push_back(e);
    endtask

    // Drive inputs, score a handshake that will complete on the coming
    // edge, then advance to just after the following falling edge.
    task automatic cycle(input bit rst, input bit rdy,
                         input bit br, input logic [15:0] tgt);
        sb_t e;
        rst_n         = rst;
        instr_ready   = rdy;
        branch_valid  = br;
        branch_target = tgt;
        #1;
        if (rst && instr_valid === 1'b1 && instr_ready) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected none",
                         instr_pc);
            end else begin
                e = sbq.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_op", instr_opcode, e.op);
                chk("sb_opd", instr_operand, e.opd);
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = {16'(i + 1), 16'(i + 10)};
        end

        tbl[0]  = mk(0,1,0,16'h0000, 0,16'h0000,16'h0000,16'h0000,16'h0000,0,16'd0);
        tbl[1]  = mk(1,1,0,16'h0000, 1,16'h0000,16'h0001,16'h000A,16'h0001,0,16'd0);
        tbl[2]  = mk(1,1,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd1);
        tbl[3]  = mk(1,0,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd1);
        tbl[4]  = mk(1,0,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd1);
        tbl[5]  = mk(1,0,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd1);
        tbl[6]  = mk(1,0,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd1);
        tbl[7]  = mk(1,1,0,16'h0000, 1,16'h0002,16'h0003,16'h000C,16'h0003,0,16'd2);
        tbl[8]  = mk(1,1,0,16'h0000, 1,16'h0003,16'h0004,16'h000D,16'h0004,0,16'd3);
        tbl[9]  = mk(1,0,1,16'h0008, 0,16'h0003,16'h0004,16'h000D,16'h0008,0,16'd3);
        tbl[10] = mk(1,0,0,16'h0000, 1,16'h0008,16'h0009,16'h0012,16'h0009,0,16'd3);
        tbl[11] = mk(1,1,1,16'h0000, 0,16'h0008,16'h0009,16'h0012,16'h0000,0,16'd4);
        tbl[12] = mk(1,1,0,16'h0000, 1,16'h0000,16'h0001,16'h000A,16'h0001,0,16'd4);
        tbl[13] = mk(1,1,0,16'h0000, 1,16'h0001,16'h0002,16'h000B,16'h0002,0,16'd5);
        tbl[14] = mk(0,1,1,16'h0005, 0,16'h0000,16'h0000,16'h0000,16'h0000,0,16'd0);
        tbl[15] = mk(1,0,0,16'h0000, 1,16'h0000,16'h0001,16'h000A,16'h0001,0,16'd0);

        push(16'h0000, 16'h0001, 16'h000A);
        push(16'h0001, 16'h0002, 16'h000B);
        push(16'h0002, 16'h0003, 16'h000C);
        push(16'h0008, 16'h0009, 16'h0012);
        push(16'h0000, 16'h0001, 16'h000A);

        for (int k = 0; k < 16; k++) begin
            cycle(tbl[k].rst, tbl[k].rdy, tbl[k].br, tbl[k].tgt);
            chk($sformatf("v%0d_valid", k), 16'(instr_valid),
                16'(tbl[k].e_valid));
            chk($sformatf("v%0d_pc", k), instr_pc, tbl[k].e_pc);
            chk($sformatf("v%0d_op", k), instr_opcode, tbl[k].e_op);
            chk($sformatf("v%0d_opd", k), instr_operand, tbl[k].e_opd);
            chk($sformatf("v%0d_addr", k), rom_addr, tbl[k].e_addr);
            chk($sformatf("v%0d_halt", k), 16'(halted),
                16'(tbl[k].e_halt));
            chk($sformatf("v%0d_cnt", k), fetch_count, tbl[k].e_cnt);
        end
        chk("tbl_sb_drain", 16'(sbq.size()), 16'd0);

        // HALT word at address 3.
        mem[3] = 32'hFFFF_0000;
        cycle(0, 0, 0, 16'h0000);
        chk("h_rst_valid", 16'(instr_valid), 16'd0);
        chk("h_rst_cnt", fetch_count, 16'd0);
        push(16'h0000, 16'h0001, 16'h000A);
        push(16'h0001, 16'h0002, 16'h000B);
        push(16'h0002, 16'h0003, 16'h000C);
        cycle(1, 1, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        cycle(1, 1, 0, 16'h0000);
        chk("h_pc2", instr_pc, 16'h0002);
        chk("h_addr3", rom_addr, 16'h0003);
        cycle(1, 1, 0, 16'h0000);
        chk("h_halted", 16'(halted), 16'd1);
        chk("h_valid0", 16'(instr_valid), 16'd0);
        chk("h_addr", rom_addr, 16'h0003);
        chk("h_cnt3", fetch_count, 16'd3);
        for (int k = 0; k < 2; k++) begin
            cycle(1, 1, 0, 16'h0000);
            chk("h_hold_halt", 16'(halted), 16'd1);
            chk("h_hold_valid", 16'(instr_valid), 16'd0);
            chk("h_hold_addr", rom_addr, 16'h0003);
            chk("h_hold_cnt", fetch_count, 16'd3);
        end
        cycle(1, 1, 1, 16'h0000);
        chk("h_br_halt", 16'(halted), 16'd0);
        chk("h_br_valid", 16'(instr_valid), 16'd0);
        chk("h_br_addr", rom_addr, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        chk("h_re_valid", 16'(instr_valid), 16'd1);
        chk("h_re_pc", instr_pc, 16'h0000);
        chk("h_re_op", instr_opcode, 16'h0001);
        push(16'h0000, 16'h0001, 16'h000A);
        cycle(1, 1, 0, 16'h0000);
        chk("h_re_cnt", fetch_count, 16'd4);
        chk("h_re_pc1", instr_pc, 16'h0001);
        cycle(1, 0, 0, 16'h0000);
        mem[3] = 32'h0004_000D;

        // PC wrap at the top of the address space.
        cycle(0, 0, 0, 16'h0000);
        cycle(1, 0, 1, 16'hFFFF);
        chk("w_addr", rom_addr, 16'hFFFF);
        chk("w_valid0", 16'(instr_valid), 16'd0);
        cycle(1, 0, 0, 16'h0000);
        chk("w_valid", 16'(instr_valid), 16'd1);
        chk("w_pc", instr_pc, 16'hFFFF);
        chk("w_op", instr_opcode, 16'h00AA);
        chk("w_opd", instr_operand, 16'h0055);
        chk("w_addr0", rom_addr, 16'h0000);
        push(16'hFFFF, 16'h00AA, 16'h0055);
        cycle(1, 1, 0, 16'h0000);
        chk("w_pc0", instr_pc, 16'h0000);
        chk("w_op0", instr_opcode, 16'h0001);
        chk("w_addr1", rom_addr, 16'h0001);
        chk("w_cnt1", fetch_count, 16'd1);
        push(16'h0000, 16'h0001, 16'h000A);
        cycle(1, 1, 0, 16'h0000);
        chk("w_cnt2", fetch_count, 16'd2);
        chk("w_pc1", instr_pc, 16'h0001);
        cycle(1, 0, 0, 16'h0000);

        chk("sb_drain", 16'(sbq.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of PC, opcode, operand and counter.
REQ-002 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-003 Parameter HALT_OPCODE, default 16'hFFFF, opcode that stops fetching.
REQ-004 Port clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port rst_n  in  1  synchronous, active-low reset.
REQ-006 Port rom_addr  out  16  program-memory word address, driven combinationally from the PC register.
REQ-007 Port rom_opcode  in  16  upper half of the addressed program word, combinational from memory.
REQ-008 Port rom_operand  in  16  lower half of the addressed program word.
REQ-009 Port branch_valid  in  1  one-cycle redirect request.
REQ-010 Port branch_target  in  16  new PC, sampled when branch_valid=1.
REQ-011 Port instr_valid  out  1  instruction register holds a valid instruction.
REQ-012 Port instr_ready  in  1  downstream decoder accepts the instruction this cycle.
REQ-013 Port instr_opcode  out  16  registered opcode.
REQ-014 Port instr_operand  out  16  registered operand.
REQ-015 Port instr_pc  out  16  address the presented instruction was fetched from.
REQ-016 Port halted  out  1  high while in HALTED state.
REQ-017 Port fetch_count  out  16  count of accepted instructions (instr_valid and instr_ready both 1).

Function
REQ-018 Two FSM states: FETCH and HALTED.
REQ-019 rom_addr shall equal the PC register at all times (zero added latency).
REQ-020 Load condition: state=FETCH, branch_valid=0, and (instr_valid=0 or instr_ready=1).
REQ-021 On load with rom_opcode!=HALT_OPCODE: instr_opcode/operand <= rom data, instr_pc <= PC, instr_valid <= 1, PC <= PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000).
REQ-022 On load with rom_opcode=HALT_OPCODE: instr_valid <= 0, PC unchanged, state <= HALTED; the HALT word is never presented downstream.
REQ-023 While instr_valid=1 and instr_ready=0: instr_* and PC hold stable (no drop, no overwrite).
REQ-024 Back-to-back throughput: with instr_ready held 1 and no branch, one new instruction per cycle.
REQ-025 branch_valid=1 in any state: PC <= branch_target, instr_valid <= 0, state <= FETCH; the first target instruction is valid 2 cycles after branch_valid.
REQ-026 branch_valid takes priority over load; a handshake in the same cycle as the branch still counts as accepted (fetch_count increments).
REQ-027 In HALTED: instr_valid=0, PC frozen, rom_addr = HALT address; only branch_valid or reset exits.
REQ-028 halted shall be 1 exactly when state=HALTED.
REQ-029 fetch_count increments by 1 per accepted handshake, wraps 16'hFFFF -> 16'h0000.

Reset
REQ-030 On rst_n=0 at a rising edge: PC=RESET_PC, state=FETCH, instr_valid=0, instr_opcode=0, instr_operand=0, instr_pc=0, halted=0, fetch_count=0.
REQ-031 Reset mid-operation discards any held instruction and overrides simultaneous branch_valid.
REQ-032 First instruction is valid on the first rising edge after rst_n deasserts.

Structure
REQ-033 Shared package fetch_pkg holds the FSM state encoding, DATA_WIDTH and HALT_OPCODE constants.
REQ-034 One sub-module, fetch_pc: PC register with reset, increment-enable, and load-target inputs; FSM, instruction register and counter live in fetch_unit.

Verification
REQ-035 Reset release, memory words 0..2 = 0x0001_000A, 0x0002_000B, 0x0003_000C, instr_ready=1 -> instr_pc 0,1,2 on consecutive cycles, fetch_count=3.
REQ-036 Stall: instr_ready=0 for 4 cycles while instr_pc=1 -> outputs hold 0x0002/0x000B, rom_addr=2, no skipped address once ready returns.
REQ-037 Branch: branch_valid with target 0x0008 while instr_valid=1 and instr_ready=0 -> instr_valid=0 next cycle, instr_pc=0x0008 two cycles after branch.
REQ-038 HALT: word 3 = 0xFFFF_0000 -> instrs 0..2 presented, then halted=1, instr_valid=0, rom_addr=3 held; branch to 0x0000 clears halted and refetches from 0.
REQ-039 Wrap: branch to 0xFFFF, non-halt word there -> next instr_pc 0xFFFF then 0x0000.
REQ-040 Reset asserted while instr_valid=1 with simultaneous branch_valid -> all outputs at reset values, PC=RESET_PC.
